// File: rtl/ula_op_issuer.sv
// ULA operation issuer: buffers commands in a small FIFO, drives one
// operation at a time onto the ULA, waits for its valid (or a timeout)
// and returns the captured result on a response handshake.
module ula_op_issuer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   ula_op_selector,
  output logic [DATA_W-1:0] ula_data_a,
  output logic [DATA_W-1:0] ula_data_b,
  input  logic              ula_valid,
  input  logic [DATA_W-1:0] ula_result,
  input  logic              ula_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam int EW = OP_W + 2 * DATA_W;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   tcnt;
  logic            push;
  logic            pop;
  logic            fifo_nonempty;

  assign fifo_nonempty = (count != '0);
  assign cmd_ready     = (count != FULL);
  assign push          = cmd_valid && cmd_ready;
  assign pop           = (state == S_IDLE) && fifo_nonempty;
  assign busy          = (state != S_IDLE) || fifo_nonempty;

  // Command storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered ULA drive, response and completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      tcnt            <= '0;
      ula_op_selector <= '0;
      ula_data_a      <= '0;
      ula_data_b      <= '0;
      rsp_valid       <= 1'b0;
      rsp_result      <= '0;
      rsp_carry       <= 1'b0;
      rsp_timeout     <= 1'b0;
      ops_done        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {ula_op_selector, ula_data_a, ula_data_b} <= mem[rd_ptr];
            state <= S_ISSUE;
          end
        end
        // ula_valid is deliberately not sampled here: it may be stale from the previous op.
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tcnt + CW'(1);
          if (ula_valid) begin
            rsp_result  <= ula_result;
            rsp_carry   <= ula_carry;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (tcnt == TLAST) begin
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
